// File: rtl/int_priority_controller.sv
// Purpose : multi-source interrupt front end; edge-detects irq lines, latches
//           pending, masks, picks the lowest index and pulses int_req + vector.
// Latency : edge sampled at posedge k -> pending at k, int_req high in cycle after k+1.
// Backpr. : one request in flight; no new dispatch until int_ack then rti;
//           int_req re-pulses every ACK_TIMEOUT+1 cycles while int_ack is withheld.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   irq_in            raw interrupt lines (rising edge requests service)
//   mask_we/wdata     mask register write (bit=1 masks the source)
//   int_ack, rti      sequencer handshake pulses
//   int_req           one-cycle request pulse
//   int_vector/int_id handler address and source index of the dispatched request
//   busy              high while waiting for ack or while the handler runs
//   pending, mask     latched pending bits, current mask register
module int_priority_controller #(
  parameter int          NUM_SRC     = 4,
  parameter int          ID_W        = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0010,
  parameter logic [15:0] VEC_STRIDE  = 16'h0008,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               rti,
  output logic               int_req,
  output logic [15:0]        int_vector,
  output logic [ID_W-1:0]    int_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT_ACK,
    S_SERVICE
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  state_t             state_q;
  logic               int_req_q;
  logic [15:0]        int_vec_q;
  logic [ID_W-1:0]    int_id_q;
  logic               busy_q;
  logic [7:0]         timer_q;

  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;

  logic [NUM_SRC-1:0] irq_edge;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] elig;
  logic [ID_W-1:0]    win_id;
  logic [15:0]        win_vec;

  always_comb begin
    irq_edge = irq_in & ~irq_prev_q;

    // Only an accepted ack retires the dispatched source's pending bit.
    pend_clr = '0;
    if (state_q == S_WAIT_ACK && int_ack) begin
      pend_clr[int_id_q] = 1'b1;
    end
    // A fresh edge on the same bit wins over the clear.
    pending_d = (pending_q & ~pend_clr) | irq_edge;

    mask_d = mask_we ? mask_wdata : mask_q;

    elig = pending_q & ~mask_q;

    // Walk downwards so the lowest set index is the last one written.
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id = ID_W'(i);
      end
    end
    win_vec = VEC_BASE + 16'(win_id) * VEC_STRIDE;
  end

  // Reset of irq_prev to all ones keeps a line held high through reset from
  // looking like a new request afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '1;
      pending_q  <= '0;
      mask_q     <= '1;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
      int_id_q  <= '0;
      busy_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig) begin
            int_id_q  <= win_id;
            int_vec_q <= win_vec;
            int_req_q <= 1'b1;
            state_q   <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          int_req_q <= 1'b0;
          timer_q   <= '0;
          busy_q    <= 1'b1;
          state_q   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          timer_q <= timer_q + 8'd1;
          if (int_ack) begin
            state_q <= S_SERVICE;
          end else if (timer_q == TIMER_LAST) begin
            // Re-pulse with the already latched id/vector; mask changes are
            // deliberately not re-evaluated here.
            int_req_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DISPATCH;
          end
        end
        S_SERVICE: begin
          if (rti) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vec_q;
  assign int_id     = int_id_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_int_priority_controller.sv
// Bench for int_priority_controller: expected dispatches are queued when the
// stimulus is driven and compared whenever the DUT pulses int_req; state
// outputs are checked directly at fixed points of each scenario.
module tb_int_priority_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_ack;
  logic        rti;
  logic        int_req;
  logic [15:0] int_vector;
  logic [1:0]  int_id;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int_priority_controller #(
    .NUM_SRC    (4),
    .ID_W       (2),
    .VEC_BASE   (16'h0010),
    .VEC_STRIDE (16'h0008),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_ack   (int_ack),
    .rti       (rti),
    .int_req   (int_req),
    .int_vector(int_vector),
    .int_id    (int_id),
    .busy      (busy),
    .pending   (pending),
    .mask      (mask)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] vec;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every int_req pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && int_req) begin
      if (sb_q.size() == 0) begin
        check("spurious_req", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("req_id", 32'(int_id), 32'(mon_e.id));
        check("req_vec", 32'(int_vector), 32'(mon_e.vec));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] id);
    exp_t e;
    e.id  = id;
    e.vec = 16'h0010 + 16'(id) * 16'h0008;
    sb_q.push_back(e);
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick(1);
    mask_we    = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!int_req && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, 32'(int_req), 32'd1);
  endtask

  // Called with int_req high (DISPATCH): ack in WAIT_ACK, then return.
  task automatic serve(input string tag);
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check({tag, "_busy_svc"}, 32'(busy), 32'd1);
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int gap;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    irq_in      = 4'b0000;
    mask_we     = 1'b0;
    mask_wdata  = 4'b0000;
    int_ack     = 1'b0;
    rti         = 1'b0;

    // ---- reset values ----
    #1;
    check("rst_req", 32'(int_req), 32'd0);
    check("rst_vec", 32'(int_vector), 32'd0);
    check("rst_id", 32'(int_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_mask", 32'(mask), 32'hf);
    tick(2);
    rst = 1'b0;
    tick(1);

    // ---- single source, latency and handshake ----
    write_mask(4'b0000);
    check("t1_mask", 32'(mask), 32'd0);
    irq_in = 4'b0100;
    push_exp(2'd2);
    tick(1);
    check("t1_pend", 32'(pending), 32'h4);
    check("t1_req_early", 32'(int_req), 32'd0);
    tick(1);
    check("t1_req", 32'(int_req), 32'd1);
    check("t1_id", 32'(int_id), 32'd2);
    check("t1_vec", 32'(int_vector), 32'h20);
    tick(1);
    check("t1_req_low", 32'(int_req), 32'd0);
    check("t1_busy_wait", 32'(busy), 32'd1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check("t1_pend_ack", 32'(pending), 32'd0);
    check("t1_busy_svc", 32'(busy), 32'd1);
    irq_in = 4'b0000;
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
    check("t1_busy_idle", 32'(busy), 32'd0);
    tick(2);

    // ---- simultaneous edges: priority ordering ----
    irq_in = 4'b1010;
    push_exp(2'd1);
    push_exp(2'd3);
    wait_req("t2_req1");
    check("t2_id1", 32'(int_id), 32'd1);
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check("t2_pend_after_ack", 32'(pending), 32'h8);
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
    irq_in = 4'b0000;
    wait_req("t2_req3");
    check("t2_id3", 32'(int_id), 32'd3);
    check("t2_vec3", 32'(int_vector), 32'h28);
    serve("t2");
    tick(2);

    // ---- line held high through reset produces no edge ----
    irq_in = 4'b0001;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    write_mask(4'b0000);
    tick(4);
    check("t3_pend_held", 32'(pending), 32'd0);
    check("t3_no_req", 32'(int_req), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    irq_in = 4'b0000;
    tick(1);
    irq_in = 4'b0001;
    push_exp(2'd0);
    wait_req("t3_req");
    check("t3_vec", 32'(int_vector), 32'h10);
    serve("t3");
    irq_in = 4'b0000;
    tick(2);

    // ---- ack timeout re-pulse ----
    irq_in = 4'b0100;
    push_exp(2'd2);
    push_exp(2'd2);
    wait_req("t4_req1");
    gap = 0;
    tick(1);
    gap++;
    while (!int_req && gap < 40) begin
      tick(1);
      gap++;
    end
    check("t4_gap", 32'(gap), 32'd16);
    check("t4_id2", 32'(int_id), 32'd2);
    serve("t4");
    check("t4_pend", 32'(pending), 32'd0);
    irq_in = 4'b0000;
    tick(2);

    // ---- masked pending, unmask, re-pend during service ----
    write_mask(4'b0001);
    irq_in = 4'b0001;
    tick(4);
    check("t5_pend_masked", 32'(pending), 32'h1);
    check("t5_no_req", 32'(int_req), 32'd0);
    push_exp(2'd0);
    write_mask(4'b0000);
    wait_req("t5_req1");
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check("t5_pend_clr", 32'(pending), 32'd0);
    irq_in = 4'b0000;
    tick(1);
    irq_in = 4'b0001;
    tick(1);
    check("t5_pend_svc", 32'(pending), 32'h1);
    check("t5_busy_svc", 32'(busy), 32'd1);
    push_exp(2'd0);
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
    wait_req("t5_req2");
    serve("t5");

    // ---- asynchronous reset during WAIT_ACK ----
    irq_in = 4'b0010;
    push_exp(2'd1);
    wait_req("t6_req");
    tick(1);
    check("t6_busy_wait", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_req", 32'(int_req), 32'd0);
    check("t6_rst_vec", 32'(int_vector), 32'd0);
    check("t6_rst_id", 32'(int_id), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    check("t6_rst_mask", 32'(mask), 32'hf);
    tick(2);
    rst = 1'b0;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    tick(3);
    check("t6_ack_ignored_busy", 32'(busy), 32'd0);
    check("t6_ack_ignored_pend", 32'(pending), 32'd0);
    check("t6_no_req", 32'(int_req), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
